display_scheduler: RTL and testbench
====================================

DISPLAY_SCHEDULER -- requirements
Module: display_scheduler

Interface
REQ-001 The block SHALL have parameter DWELL_TICKS, default 2000, which sets the clk_1khz cycles a granted source holds the display before rotation is considered.
REQ-002 The block SHALL have parameter ALERT_TICKS, default 1000, which sets the total alert display duration in cycles.
REQ-003 The block SHALL have parameter BLINK_HALF, default 250, which sets the cycles per alert blink phase (on or off).
REQ-004 The block SHALL have port clk_1khz, input, 1 bit: the clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: reset, synchronous, active-high; clock clk_1khz.
REQ-006 The block SHALL have port src_req, input, 3 bits: bit i high means source i requests the display.
REQ-007 The block SHALL have port src_data, input, 48 bits: the 4-digit BCD value of source i on bits [16i+15:16i].
REQ-008 The block SHALL have port alert_req, input, 1 bit: a priority message request, level-sampled.
REQ-009 The block SHALL have port alert_data, input, 16 bits: the 4-digit BCD alert value.
REQ-010 The block SHALL have port src_gnt, output, 3 bits: a one-hot grant, or zero when no source is granted.
REQ-011 The block SHALL have port alert_ack, output, 1 bit: a single-cycle pulse that accepts an alert.
REQ-012 The block SHALL have port bcd_out, output, 16 bits: the BCD word for the 7-segment driver, where nibble 4'hF means a blank digit.
REQ-013 The block SHALL have port state_out, output, 2 bits: the current state, encoded IDLE=0, SHOW=1, ALERT=2.

Function
REQ-014 The block SHALL implement the states IDLE, SHOW and ALERT; state 3 is unreachable and SHALL recover to IDLE on the next cycle.
REQ-015 In IDLE, the block SHALL drive bcd_out=16'hFFFF and src_gnt=0; if any src_req bit is high, it SHALL grant the winner and enter SHOW on the next edge.
REQ-016 Arbitration SHALL be round-robin: the search starts at (last_granted+1) mod 3, and after reset last_granted=2, so source 0 has first priority.
REQ-017 In SHOW, bcd_out SHALL equal src_data of the granted source, registered, with 1-cycle latency from src_data to bcd_out.
REQ-018 The dwell counter SHALL clear on every new grant and increment each SHOW cycle; when it reaches DWELL_TICKS-1:
- if another source is requesting, the grant SHALL move to the next requester by round-robin;
- otherwise the current grant SHALL be kept and the counter SHALL clear.
REQ-019 If the granted source drops src_req, on the next edge:
- the grant SHALL move to the next requester by round-robin;
- if no source is requesting, the block SHALL go to IDLE, with src_gnt=0 and bcd_out=16'hFFFF.
REQ-020 Regrant on the same source SHALL NOT produce a src_gnt glitch; a grant change SHALL pass directly from one one-hot value to the next, with no zero cycle in between.
REQ-021 With alert_req high in IDLE or SHOW, on the next edge the block SHALL:
- latch alert_data;
- pulse alert_ack for exactly 1 cycle;
- enter ALERT with src_gnt=0 and the alert counter cleared.
REQ-022 Alert SHALL take priority over a simultaneous src_req change or dwell expiry on the same edge.
REQ-023 In ALERT, bcd_out SHALL show the latched alert value while (alert counter / BLINK_HALF) is even, and 16'hFFFF while it is odd.
REQ-024 alert_req while already in ALERT SHALL be ignored: no ack and no relatch.
REQ-025 When the alert counter reaches ALERT_TICKS-1, the block SHALL re-arbitrate from last_granted on the next edge:
- it SHALL enter SHOW with a fresh dwell count if any src_req bit is high;
- otherwise it SHALL enter IDLE.
REQ-026 Counters SHALL be the minimum width that holds their parameter-1 value and SHALL never wrap past their terminal value.
REQ-027 src_data nibbles greater than 9 SHALL pass through unchanged; blanking them is the driver's job.

Reset
REQ-028 While reset is high at a clock edge, the block SHALL set:
- state to IDLE, src_gnt=0, alert_ack=0;
- bcd_out=16'hFFFF, state_out=0;
- all counters to 0 and last_granted=2.
REQ-029 Reset SHALL override all other inputs, including a mid-SHOW or mid-ALERT reset, and normal operation SHALL resume on the first edge after reset falls.

Verification
REQ-030 The bench SHALL cover: reset, then src_req=3'b001 and src_data[15:0]=16'h1234 -> next edge src_gnt=001 and state_out=1; the following edge bcd_out=16'h1234.
REQ-031 The bench SHALL cover: src_req=3'b101 held with DWELL_TICKS=4 -> grants cycle 001,100,001 every 4 cycles, with no zero cycle between grants.
REQ-032 The bench SHALL cover: source 1 granted, then src_req drops to 000 -> next edge src_gnt=0, bcd_out=16'hFFFF, state_out=0.
REQ-033 The bench SHALL cover: in SHOW, alert_req=1 with alert_data=16'h0911, ALERT_TICKS=8 and BLINK_HALF=2 -> alert_ack pulses once; bcd_out shows 0911,0911,FFFF,FFFF,0911,0911,FFFF,FFFF; the block then returns to SHOW granting the next requester.
REQ-034 The bench SHALL cover: alert_req held high throughout ALERT -> exactly one alert_ack, and a new ack only after the return to SHOW or IDLE.
REQ-035 The bench SHALL cover: reset asserted mid-ALERT -> next edge all outputs at their reset values; after reset falls with src_req=3'b010, source 1 is granted.

Source files
------------

// File: rtl/display_scheduler.sv
// Display scheduler: round-robin sharing of one 4-digit BCD display among
// three sources, with a blinking priority alert that pre-empts them.
module display_scheduler #(
    parameter int unsigned DWELL_TICKS = 2000,
    parameter int unsigned ALERT_TICKS = 1000,
    parameter int unsigned BLINK_HALF  = 250
) (
    input  logic        clk_1khz,
    input  logic        reset,
    input  logic [2:0]  src_req,
    input  logic [47:0] src_data,
    input  logic        alert_req,
    input  logic [15:0] alert_data,
    output logic [2:0]  src_gnt,
    output logic        alert_ack,
    output logic [15:0] bcd_out,
    output logic [1:0]  state_out
);

    localparam int unsigned DW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
    localparam int unsigned AW = (ALERT_TICKS > 1) ? $clog2(ALERT_TICKS) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_TICKS - 1);
    localparam logic [AW-1:0] ALERT_LAST = AW'(ALERT_TICKS - 1);
    localparam logic [15:0]   BLANK      = 16'hFFFF;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShow  = 2'd1,
        StAlert = 2'd2,
        StBad   = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic [2:0]     gnt_q, gnt_d;
    logic [1:0]     last_q, last_d;   // index of the most recently granted source
    logic [DW-1:0]  dwell_q, dwell_d;
    logic [AW-1:0]  acnt_q, acnt_d;
    logic [15:0]    aval_q, aval_d;
    logic           ack_q, ack_d;
    logic [15:0]    bcd_q, bcd_d;

    function automatic logic [2:0] onehot(input logic [1:0] idx);
        case (idx)
            2'd0:    onehot = 3'b001;
            2'd1:    onehot = 3'b010;
            2'd2:    onehot = 3'b100;
            default: onehot = 3'b000;
        endcase
    endfunction

    // Search starts one past 'last'; caller guarantees at least one candidate.
    function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
        logic [1:0] s0, s1, s2;
        case (last)
            2'd0:    begin s0 = 2'd1; s1 = 2'd2; s2 = 2'd0; end
            2'd1:    begin s0 = 2'd2; s1 = 2'd0; s2 = 2'd1; end
            default: begin s0 = 2'd0; s1 = 2'd1; s2 = 2'd2; end
        endcase
        if ((req & onehot(s0)) != 3'b000)      rr_pick = s0;
        else if ((req & onehot(s1)) != 3'b000) rr_pick = s1;
        else                                   rr_pick = s2;
    endfunction

    function automatic logic [15:0] sel_data(input logic [47:0] data, input logic [1:0] idx);
        case (idx)
            2'd0:    sel_data = data[15:0];
            2'd1:    sel_data = data[31:16];
            default: sel_data = data[47:32];
        endcase
    endfunction

    // Next-state logic: arbitration, dwell/alert counting and output words.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        dwell_d = dwell_q;
        acnt_d  = acnt_q;
        aval_d  = aval_q;
        ack_d   = 1'b0;

        case (state_q)
            StIdle, StShow: begin
                if (alert_req) begin
                    // Alert wins over any grant change on the same edge.
                    state_d = StAlert;
                    aval_d  = alert_data;
                    ack_d   = 1'b1;
                    acnt_d  = '0;
                    dwell_d = '0;
                end else if (state_q == StIdle) begin
                    if (src_req != 3'b000) begin
                        state_d = StShow;
                        last_d  = rr_pick(src_req, last_q);
                        dwell_d = '0;
                    end
                end else if ((src_req & onehot(last_q)) == 3'b000) begin
                    dwell_d = '0;
                    if (src_req != 3'b000) begin
                        last_d = rr_pick(src_req, last_q);
                    end else begin
                        state_d = StIdle;
                    end
                end else if (dwell_q == DWELL_LAST) begin
                    dwell_d = '0;
                    if ((src_req & ~onehot(last_q)) != 3'b000) begin
                        last_d = rr_pick(src_req & ~onehot(last_q), last_q);
                    end
                end else begin
                    dwell_d = dwell_q + DW'(1);
                end
            end
            StAlert: begin
                if (acnt_q == ALERT_LAST) begin
                    acnt_d  = '0;
                    dwell_d = '0;
                    if (src_req != 3'b000) begin
                        state_d = StShow;
                        last_d  = rr_pick(src_req, last_q);
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    acnt_d = acnt_q + AW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        gnt_d = (state_d == StShow) ? onehot(last_d) : 3'b000;

        case (state_d)
            StShow:  bcd_d = sel_data(src_data, last_d);
            StAlert: bcd_d = (((32'(acnt_d) / BLINK_HALF) % 2) != 0) ? BLANK : aval_d;
            default: bcd_d = BLANK;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_1khz) begin
        if (reset) begin
            state_q <= StIdle;
            gnt_q   <= 3'b000;
            last_q  <= 2'd2;
            dwell_q <= '0;
            acnt_q  <= '0;
            aval_q  <= BLANK;
            ack_q   <= 1'b0;
            bcd_q   <= BLANK;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            dwell_q <= dwell_d;
            acnt_q  <= acnt_d;
            aval_q  <= aval_d;
            ack_q   <= ack_d;
            bcd_q   <= bcd_d;
        end
    end

    assign src_gnt   = gnt_q;
    assign alert_ack = ack_q;
    assign bcd_out   = bcd_q;
    assign state_out = state_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Directed self-checking bench for display_scheduler with short timing parameters.
module tb_display_scheduler;

    logic        clk_1khz = 1'b0;
    logic        reset;
    logic [2:0]  src_req;
    logic [47:0] src_data;
    logic        alert_req;
    logic [15:0] alert_data;
    logic [2:0]  src_gnt;
    logic        alert_ack;
    logic [15:0] bcd_out;
    logic [1:0]  state_out;

    int n_checks = 0;
    int n_fail   = 0;

    display_scheduler #(
        .DWELL_TICKS(4),
        .ALERT_TICKS(8),
        .BLINK_HALF (2)
    ) dut (
        .clk_1khz  (clk_1khz),
        .reset     (reset),
        .src_req   (src_req),
        .src_data  (src_data),
        .alert_req (alert_req),
        .alert_data(alert_data),
        .src_gnt   (src_gnt),
        .alert_ack (alert_ack),
        .bcd_out   (bcd_out),
        .state_out (state_out)
    );

    always #5 clk_1khz = ~clk_1khz;

    // Advance one rising edge and settle past it.
    task automatic tick();
        @(posedge clk_1khz);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        src_req   = 3'b000;
        alert_req = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        src_req    = 3'b111;
        alert_req  = 1'b1;
        alert_data = 16'h5555;
        src_data   = 48'h3333_2222_1111;
        tick();
        tick();
        n_checks++; if (src_gnt !== 3'b000) begin n_fail++; $display("FAIL reset_gnt got %b want 000", src_gnt); end
        n_checks++; if (alert_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack got %b want 0", alert_ack); end
        n_checks++; if (bcd_out !== 16'hFFFF) begin n_fail++; $display("FAIL reset_bcd got %h want FFFF", bcd_out); end
        n_checks++; if (state_out !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", state_out); end
        src_req   = 3'b000;
        alert_req = 1'b0;
        reset     = 1'b0;
        tick();
        n_checks++; if (state_out !== 2'd0) begin n_fail++; $display("FAIL idle_state got %0d want 0", state_out); end
    endtask

    task automatic test_single_grant();
        do_reset();
        src_data = 48'h3333_2222_1234;
        src_req  = 3'b001;
        tick();
        n_checks++; if (src_gnt !== 3'b001) begin n_fail++; $display("FAIL single_gnt got %b want 001", src_gnt); end
        n_checks++; if (state_out !== 2'd1) begin n_fail++; $display("FAIL single_state got %0d want 1", state_out); end
        tick();
        n_checks++; if (bcd_out !== 16'h1234) begin n_fail++; $display("FAIL single_bcd got %h want 1234", bcd_out); end
        // Nibbles above 9 are passed through untouched.
        src_data = 48'h3333_2222_ABCF;
        tick();
        n_checks++; if (bcd_out !== 16'hABCF) begin n_fail++; $display("FAIL passthru_bcd got %h want ABCF", bcd_out); end
        // Lone requester keeps the grant across dwell expiry.
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++; if (src_gnt !== 3'b001) begin n_fail++; $display("FAIL hold_gnt[%0d] got %b want 001", i, src_gnt); end
        end
        src_req = 3'b000;
        tick();
        n_checks++; if (state_out !== 2'd0) begin n_fail++; $display("FAIL single_idle got %0d want 0", state_out); end
    endtask

    task automatic test_round_robin();
        logic [2:0]  exp_gnt;
        logic [15:0] exp_bcd;
        do_reset();
        src_data = 48'h3333_2222_1111;
        src_req  = 3'b101;
        for (int i = 0; i < 12; i++) begin
            tick();
            exp_gnt = (((i / 4) % 2) == 0) ? 3'b001 : 3'b100;
            exp_bcd = (exp_gnt == 3'b001) ? 16'h1111 : 16'h3333;
            n_checks++; if (src_gnt !== exp_gnt) begin n_fail++; $display("FAIL rr_gnt[%0d] got %b want %b", i, src_gnt, exp_gnt); end
            if ((i % 4) != 0) begin
                n_checks++; if (bcd_out !== exp_bcd) begin n_fail++; $display("FAIL rr_bcd[%0d] got %h want %h", i, bcd_out, exp_bcd); end
            end
        end
    endtask

    task automatic test_drop();
        // Source 0 is granted on entry; it drops in favour of source 1.
        src_req = 3'b010;
        tick();
        n_checks++; if (src_gnt !== 3'b010) begin n_fail++; $display("FAIL drop_move_gnt got %b want 010", src_gnt); end
        tick();
        n_checks++; if (bcd_out !== 16'h2222) begin n_fail++; $display("FAIL drop_move_bcd got %h want 2222", bcd_out); end
        src_req = 3'b000;
        tick();
        n_checks++; if (src_gnt !== 3'b000) begin n_fail++; $display("FAIL drop_gnt got %b want 000", src_gnt); end
        n_checks++; if (bcd_out !== 16'hFFFF) begin n_fail++; $display("FAIL drop_bcd got %h want FFFF", bcd_out); end
        n_checks++; if (state_out !== 2'd0) begin n_fail++; $display("FAIL drop_state got %0d want 0", state_out); end
    endtask

    task automatic test_alert();
        logic [15:0] pattern [8];
        pattern = '{16'h0911, 16'h0911, 16'hFFFF, 16'hFFFF,
                    16'h0911, 16'h0911, 16'hFFFF, 16'hFFFF};
        do_reset();
        src_req = 3'b011;
        tick();
        n_checks++; if (src_gnt !== 3'b001) begin n_fail++; $display("FAIL alert_pre_gnt got %b want 001", src_gnt); end
        alert_req  = 1'b1;
        alert_data = 16'h0911;
        for (int i = 0; i < 8; i++) begin
            tick();
            alert_req = 1'b0;
            n_checks++; if (bcd_out !== pattern[i]) begin n_fail++; $display("FAIL alert_bcd[%0d] got %h want %h", i, bcd_out, pattern[i]); end
            n_checks++; if (alert_ack !== (i == 0)) begin n_fail++; $display("FAIL alert_ack[%0d] got %b want %b", i, alert_ack, i == 0); end
            n_checks++; if (state_out !== 2'd2) begin n_fail++; $display("FAIL alert_state[%0d] got %0d want 2", i, state_out); end
            n_checks++; if (src_gnt !== 3'b000) begin n_fail++; $display("FAIL alert_gnt[%0d] got %b want 000", i, src_gnt); end
        end
        tick();
        n_checks++; if (state_out !== 2'd1) begin n_fail++; $display("FAIL alert_ret_state got %0d want 1", state_out); end
        n_checks++; if (src_gnt !== 3'b010) begin n_fail++; $display("FAIL alert_ret_gnt got %b want 010", src_gnt); end
    endtask

    task automatic test_alert_hold();
        int acks;
        // Source 1 granted, requests 011 still pending.
        alert_req  = 1'b1;
        alert_data = 16'h1111;
        tick();
        n_checks++; if (alert_ack !== 1'b1) begin n_fail++; $display("FAIL hold_first_ack got %b want 1", alert_ack); end
        alert_data = 16'h2222;
        acks = 0;
        for (int i = 1; i < 8; i++) begin
            tick();
            if (alert_ack === 1'b1) acks++;
            if (i == 1) begin
                n_checks++; if (bcd_out !== 16'h1111) begin n_fail++; $display("FAIL hold_relatch got %h want 1111", bcd_out); end
            end
        end
        n_checks++; if (acks !== 0) begin n_fail++; $display("FAIL hold_extra_acks got %0d want 0", acks); end
        tick();
        n_checks++; if (state_out !== 2'd1) begin n_fail++; $display("FAIL hold_ret_state got %0d want 1", state_out); end
        n_checks++; if (src_gnt !== 3'b001) begin n_fail++; $display("FAIL hold_ret_gnt got %b want 001", src_gnt); end
        n_checks++; if (alert_ack !== 1'b0) begin n_fail++; $display("FAIL hold_ret_ack got %b want 0", alert_ack); end
        tick();
        n_checks++; if (alert_ack !== 1'b1) begin n_fail++; $display("FAIL hold_new_ack got %b want 1", alert_ack); end
        n_checks++; if (state_out !== 2'd2) begin n_fail++; $display("FAIL hold_new_state got %0d want 2", state_out); end
        alert_req = 1'b0;
    endtask

    task automatic test_reset_mid_alert();
        tick();
        n_checks++; if (state_out !== 2'd2) begin n_fail++; $display("FAIL mid_pre_state got %0d want 2", state_out); end
        reset   = 1'b1;
        src_req = 3'b010;
        tick();
        n_checks++; if (src_gnt !== 3'b000) begin n_fail++; $display("FAIL mid_gnt got %b want 000", src_gnt); end
        n_checks++; if (alert_ack !== 1'b0) begin n_fail++; $display("FAIL mid_ack got %b want 0", alert_ack); end
        n_checks++; if (bcd_out !== 16'hFFFF) begin n_fail++; $display("FAIL mid_bcd got %h want FFFF", bcd_out); end
        n_checks++; if (state_out !== 2'd0) begin n_fail++; $display("FAIL mid_state got %0d want 0", state_out); end
        reset = 1'b0;
        tick();
        n_checks++; if (src_gnt !== 3'b010) begin n_fail++; $display("FAIL mid_regrant got %b want 010", src_gnt); end
        n_checks++; if (state_out !== 2'd1) begin n_fail++; $display("FAIL mid_regrant_state got %0d want 1", state_out); end
    endtask

    initial begin
        test_reset();
        test_single_grant();
        test_round_robin();
        test_drop();
        test_alert();
        test_alert_hold();
        test_reset_mid_alert();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
